// File: rtl/seq_shift_rotate_pkg.sv
// Shared opcode constants, FSM state encoding and opcode validity helper
// for the multi-cycle shift/rotate unit.
package shift_rotate_pkg;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  function automatic logic is_valid_op(input logic [2:0] op);
    return (op <= OP_ROR);
  endfunction

endpackage

// File: rtl/seq_shift_rotate_if.sv
// Request and result handshake bundle for seq_shift_rotate.
interface seq_shift_rotate_if #(parameter int WIDTH = 8);
  localparam int AMT_W = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [2:0]       opcode;
  logic [AMT_W-1:0] amount;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_err;

  modport master (
    output in_valid, in_data, opcode, amount, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  in_valid, in_data, opcode, amount, out_ready,
    output in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/seq_shift_rotate_step.sv
// One combinational shift/rotate step of k bits; k=0 passes data through.
module shift_rotate_step
  import shift_rotate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic [WIDTH-1:0] data,
  input  logic [2:0]       op,
  input  logic [AMT_W-1:0] k,
  input  logic             sign,
  output logic [WIDTH-1:0] result
);

  logic [2*WIDTH-1:0] sra_ext;
  logic [WIDTH-1:0]   rot_l;
  logic [WIDTH-1:0]   rot_r;

  always_comb begin
    sra_ext = {{WIDTH{sign}}, data} >> k;
    // a shift by WIDTH yields zero, so k=0 rotates collapse to data
    rot_l   = (data << k) | (data >> (WIDTH - int'(k)));
    rot_r   = (data >> k) | (data << (WIDTH - int'(k)));
    result  = data;
    case (op)
      OP_SLL:  result = data << k;
      OP_SRL:  result = data >> k;
      OP_SRA:  result = sra_ext[WIDTH-1:0];
      OP_ROL:  result = rot_l;
      OP_ROR:  result = rot_r;
      default: result = data;
    endcase
  end

endmodule

// File: rtl/seq_shift_rotate.sv
// Multi-cycle shift/rotate unit: STEP bits per clock between two valid/ready handshakes.
//  state   | meaning
//  S_IDLE  | ready for a request
//  S_SHIFT | stepping the operand, remaining > 0
//  S_DONE  | result presented until out_ready
module seq_shift_rotate
  import shift_rotate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  seq_shift_rotate_if.slave   bus,
  output logic                busy
);

  localparam int AMT_W = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q;
  logic [2:0]       op_q;
  logic [AMT_W-1:0] rem_q;
  logic [AMT_W-1:0] k_amt;
  logic             sign_q;
  logic             err_q;
  logic             accept;
  logic [WIDTH-1:0] step_res;

  assign accept = bus.in_valid && (state_q == S_IDLE);
  assign k_amt  = (rem_q < AMT_W'(STEP)) ? rem_q : AMT_W'(STEP);

  shift_rotate_step #(.WIDTH(WIDTH), .AMT_W(AMT_W)) u_step (
    .data   (data_q),
    .op     (op_q),
    .k      (k_amt),
    .sign   (sign_q),
    .result (step_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bus.in_ready  = (state_q == S_IDLE);
    bus.out_valid = (state_q == S_DONE);
    bus.out_data  = data_q;
    bus.out_err   = err_q && (state_q == S_DONE);
    busy          = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          if ((bus.amount != '0) && is_valid_op(bus.opcode)) state_d = S_SHIFT;
          else                                               state_d = S_DONE;
        end
      end
      S_SHIFT: if (rem_q == k_amt) state_d = S_DONE;
      S_DONE:  if (bus.out_ready)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      op_q   <= '0;
      rem_q  <= '0;
      sign_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (accept) begin
      data_q <= bus.in_data;
      op_q   <= bus.opcode;
      rem_q  <= bus.amount;
      sign_q <= bus.in_data[WIDTH-1];
      err_q  <= !is_valid_op(bus.opcode);
    end else if (state_q == S_SHIFT) begin
      data_q <= step_res;
      rem_q  <= rem_q - k_amt;
    end
  end

endmodule

// File: tb/tb_seq_shift_rotate.sv
// Directed bench for seq_shift_rotate: vector table plus hold and mid-operation reset sequences.
module tb_seq_shift_rotate;

  logic clk;
  logic rst_n;
  logic busy1, busy2;

  seq_shift_rotate_if #(.WIDTH(8)) bus1 ();
  seq_shift_rotate_if #(.WIDTH(8)) bus2 ();

  seq_shift_rotate #(.WIDTH(8), .STEP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .busy(busy1));
  seq_shift_rotate #(.WIDTH(8), .STEP(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2), .busy(busy2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         which;
    logic [2:0] op;
    logic [7:0] d;
    logic [2:0] amt;
    logic [7:0] exp_d;
    logic       exp_e;
    int         exp_lat;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input int which, input logic v, input logic [2:0] op,
                           input logic [7:0] d, input logic [2:0] amt);
    if (which == 0) begin
      bus1.in_valid = v; bus1.opcode = op; bus1.in_data = d; bus1.amount = amt;
    end else begin
      bus2.in_valid = v; bus2.opcode = op; bus2.in_data = d; bus2.amount = amt;
    end
  endtask

  function automatic logic get_valid(input int which);
    return (which == 0) ? bus1.out_valid : bus2.out_valid;
  endfunction

  task automatic run_op(input int which, input logic [2:0] op, input logic [7:0] d,
                        input logic [2:0] amt, output logic [7:0] rd, output logic re,
                        output int lat);
    drive_req(which, 1'b1, op, d, amt);
    @(posedge clk); #1;
    drive_req(which, 1'b0, 3'b000, 8'h00, 3'd0);
    lat = 1;
    while (!get_valid(which) && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = (which == 0) ? bus1.out_data : bus2.out_data;
    re = (which == 0) ? bus1.out_err  : bus2.out_err;
    if (which == 0) bus1.out_ready = 1'b1; else bus2.out_ready = 1'b1;
    @(posedge clk); #1;
    bus1.out_ready = 1'b0;
    bus2.out_ready = 1'b0;
  endtask

  logic [7:0] rd;
  logic       re;
  int         lat;

  initial begin
    vecs[0]  = '{0, 3'b000, 8'hB5, 3'd3, 8'hA8, 1'b0, 4};
    vecs[1]  = '{0, 3'b010, 8'hB5, 3'd2, 8'hED, 1'b0, 3};
    vecs[2]  = '{0, 3'b001, 8'hB5, 3'd2, 8'h2D, 1'b0, 3};
    vecs[3]  = '{0, 3'b001, 8'hB5, 3'd0, 8'hB5, 1'b0, 1};
    vecs[4]  = '{0, 3'b011, 8'hB5, 3'd4, 8'h5B, 1'b0, 5};
    vecs[5]  = '{0, 3'b100, 8'hB5, 3'd1, 8'hDA, 1'b0, 2};
    vecs[6]  = '{0, 3'b110, 8'hB5, 3'd3, 8'hB5, 1'b1, 1};
    vecs[7]  = '{0, 3'b010, 8'h35, 3'd3, 8'h06, 1'b0, 4};
    vecs[8]  = '{1, 3'b100, 8'hB5, 3'd7, 8'h6B, 1'b0, 5};
    vecs[9]  = '{1, 3'b000, 8'hB5, 3'd3, 8'hA8, 1'b0, 3};
    vecs[10] = '{1, 3'b010, 8'hB5, 3'd2, 8'hED, 1'b0, 2};

    rst_n = 1'b0;
    drive_req(0, 1'b0, 3'b000, 8'h00, 3'd0);
    drive_req(1, 1'b0, 3'b000, 8'h00, 3'd0);
    bus1.out_ready = 1'b0;
    bus2.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus1.out_valid), 32'd0);
    chk("rst_out_data",  32'(bus1.out_data),  32'h00);
    chk("rst_out_err",   32'(bus1.out_err),   32'd0);
    chk("rst_busy",      32'(busy1),          32'd0);
    chk("rst_in_ready",  32'(bus1.in_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].which, vecs[i].op, vecs[i].d, vecs[i].amt, rd, re, lat);
      chk($sformatf("vec%0d_data", i), 32'(rd),  32'(vecs[i].exp_d));
      chk($sformatf("vec%0d_err", i),  32'(re),  32'(vecs[i].exp_e));
      chk($sformatf("vec%0d_lat", i),  32'(lat), 32'(vecs[i].exp_lat));
    end

    // result held while out_ready stays low; competing request must be ignored
    drive_req(0, 1'b1, 3'b000, 8'h01, 3'd2);
    @(posedge clk); #1;
    drive_req(0, 1'b0, 3'b000, 8'h00, 3'd0);
    lat = 1;
    while (!bus1.out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("hold_lat", 32'(lat), 32'd3);
    drive_req(0, 1'b1, 3'b011, 8'hFF, 3'd1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("hold%0d_valid", c), 32'(bus1.out_valid), 32'd1);
      chk($sformatf("hold%0d_data", c),  32'(bus1.out_data),  32'h04);
      chk($sformatf("hold%0d_ready", c), 32'(bus1.in_ready),  32'd0);
    end
    drive_req(0, 1'b0, 3'b000, 8'h00, 3'd0);
    bus1.out_ready = 1'b1;
    @(posedge clk); #1;
    bus1.out_ready = 1'b0;
    chk("hold_after_valid", 32'(bus1.out_valid), 32'd0);
    chk("hold_after_busy",  32'(busy1),          32'd0);
    @(posedge clk); #1;
    chk("hold_idle_busy",   32'(busy1),          32'd0);

    // reset while shifting
    drive_req(0, 1'b1, 3'b000, 8'hB5, 3'd3);
    @(posedge clk); #1;
    drive_req(0, 1'b0, 3'b000, 8'h00, 3'd0);
    @(posedge clk); #1;
    chk("mid_busy_before", 32'(busy1), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus1.out_valid), 32'd0);
    chk("mid_rst_data",  32'(bus1.out_data),  32'h00);
    chk("mid_rst_err",   32'(bus1.out_err),   32'd0);
    chk("mid_rst_busy",  32'(busy1),          32'd0);
    chk("mid_rst_ready", 32'(bus1.in_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(0, 3'b000, 8'h01, 3'd1, rd, re, lat);
    chk("post_rst_data", 32'(rd),  32'h02);
    chk("post_rst_err",  32'(re),  32'd0);
    chk("post_rst_lat",  32'(lat), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
